// File: rtl/sram_arbiter.sv
// Two-master arbiter sharing one ext_sram stb/ack port between instruction fetch (port 0)
// and data load/store (port 1); one downstream transaction at a time, all outputs registered.
module sram_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int CW           = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i0_stb,
  input  logic        i0_rw,
  input  logic [31:0] i0_addr,
  input  logic [31:0] i0_dtw,
  output logic        i0_ack,
  output logic [31:0] i0_dtr,
  input  logic        i1_stb,
  input  logic        i1_rw,
  input  logic [31:0] i1_addr,
  input  logic [31:0] i1_dtw,
  output logic        i1_ack,
  output logic [31:0] i1_dtr,
  output logic        m_stb,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  input  logic        m_ack,
  input  logic [31:0] m_dtr,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_DATA_RUN);

  state_t        r_state, w_state;
  logic [CW-1:0] r_run, w_run;
  logic          r_m_stb, w_m_stb;
  logic          r_m_rw, w_m_rw;
  logic [31:0]   r_m_addr, w_m_addr;
  logic [31:0]   r_m_dtw, w_m_dtw;
  logic          r_i0_ack, w_i0_ack;
  logic          r_i1_ack, w_i1_ack;
  logic [31:0]   r_i0_dtr, w_i0_dtr;
  logic [31:0]   r_i1_dtr, w_i1_dtr;
  logic          r_grant, w_grant;
  logic          r_busy, w_busy;
  logic          w_pick0;

  always_comb begin
    w_state  = r_state;
    w_run    = r_run;
    w_m_stb  = r_m_stb;
    w_m_rw   = r_m_rw;
    w_m_addr = r_m_addr;
    w_m_dtw  = r_m_dtw;
    w_i0_ack = r_i0_ack;
    w_i1_ack = r_i1_ack;
    w_i0_dtr = r_i0_dtr;
    w_i1_dtr = r_i1_dtr;
    w_grant  = r_grant;
    w_pick0  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i0_stb)
          w_run = '0;
        if (i0_stb || i1_stb) begin
          // Data port wins by default; fetch wins when alone or once the data run has saturated.
          w_pick0 = i0_stb && (!i1_stb || (r_run == RUN_MAX));
          if (w_pick0) begin
            w_grant  = 1'b0;
            w_m_rw   = i0_rw;
            w_m_addr = i0_addr;
            w_m_dtw  = i0_dtw;
            w_run    = '0;
          end else begin
            w_grant  = 1'b1;
            w_m_rw   = i1_rw;
            w_m_addr = i1_addr;
            w_m_dtw  = i1_dtw;
            if (i0_stb && (r_run != RUN_MAX))
              w_run = r_run + CW'(1);
          end
          w_m_stb = 1'b1;
          w_state = ISSUE;
        end
      end
      ISSUE: begin
        w_m_stb = 1'b0;
        w_state = WAIT;
      end
      WAIT: begin
        if (m_ack) begin
          if (r_grant) begin
            w_i1_dtr = m_dtr;
            w_i1_ack = 1'b1;
          end else begin
            w_i0_dtr = m_dtr;
            w_i0_ack = 1'b1;
          end
          w_state = DONE;
        end
      end
      DONE: begin
        w_i0_ack = 1'b0;
        w_i1_ack = 1'b0;
        w_state  = IDLE;
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_run    <= '0;
      r_m_stb  <= 1'b0;
      r_m_rw   <= 1'b0;
      r_m_addr <= '0;
      r_m_dtw  <= '0;
      r_i0_ack <= 1'b0;
      r_i1_ack <= 1'b0;
      r_i0_dtr <= '0;
      r_i1_dtr <= '0;
      r_grant  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_run    <= w_run;
      r_m_stb  <= w_m_stb;
      r_m_rw   <= w_m_rw;
      r_m_addr <= w_m_addr;
      r_m_dtw  <= w_m_dtw;
      r_i0_ack <= w_i0_ack;
      r_i1_ack <= w_i1_ack;
      r_i0_dtr <= w_i0_dtr;
      r_i1_dtr <= w_i1_dtr;
      r_grant  <= w_grant;
      r_busy   <= w_busy;
    end
  end

  assign m_stb  = r_m_stb;
  assign m_rw   = r_m_rw;
  assign m_addr = r_m_addr;
  assign m_dtw  = r_m_dtw;
  assign i0_ack = r_i0_ack;
  assign i1_ack = r_i1_ack;
  assign i0_dtr = r_i0_dtr;
  assign i1_dtr = r_i1_dtr;
  assign grant  = r_grant;
  assign busy   = r_busy;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single-master transactions plus
// hand-written sequences for contention, starvation, back-to-back issue and reset.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i0_stb, i0_rw, i1_stb, i1_rw;
  logic [31:0] i0_addr, i0_dtw, i1_addr, i1_dtw;
  logic        i0_ack, i1_ack;
  logic [31:0] i0_dtr, i1_dtr;
  logic        m_stb, m_rw, m_ack, grant, busy;
  logic [31:0] m_addr, m_dtw, m_dtr;

  sram_arbiter #(.MAX_DATA_RUN(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .i0_stb(i0_stb), .i0_rw(i0_rw), .i0_addr(i0_addr), .i0_dtw(i0_dtw),
    .i0_ack(i0_ack), .i0_dtr(i0_dtr),
    .i1_stb(i1_stb), .i1_rw(i1_rw), .i1_addr(i1_addr), .i1_dtw(i1_dtw),
    .i1_ack(i1_ack), .i1_dtr(i1_dtr),
    .m_stb(m_stb), .m_rw(m_rw), .m_addr(m_addr), .m_dtw(m_dtw),
    .m_ack(m_ack), .m_dtr(m_dtr), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        g;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
  } iss_t;

  typedef struct {
    logic        port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic [31:0] rdata;
    int          lat;
    logic        exp_grant;
    logic [31:0] exp_dtr;
  } vec_t;

  iss_t        iss_q[$];
  int          cyc = 0;
  int          stb_long = 0;
  logic        stb_prev = 1'b0, a0_prev = 1'b0, a1_prev = 1'b0;
  int          ack0_hi = 0, ack1_hi = 0, ack0_pulses = 0, ack1_pulses = 0;
  int          tb_lat = 1;
  logic [31:0] tb_rdata = 32'h0;
  int          n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_port(input logic p, input logic stb, input logic rw,
                            input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      i1_stb = stb; i1_rw = rw; i1_addr = a; i1_dtw = d;
    end else begin
      i0_stb = stb; i0_rw = rw; i0_addr = a; i0_dtw = d;
    end
  endtask

  task automatic wait_ack(input logic p, input int maxc, output logic ok, output logic [31:0] dtr);
    int k;
    ok = 1'b0;
    dtr = '0;
    k = 0;
    while (!ok && k < maxc) begin
      @(posedge clk);
      #1;
      if (p ? i1_ack : i0_ack) begin
        ok = 1'b1;
        dtr = p ? i1_dtr : i0_dtr;
      end
      k++;
    end
  endtask

  // Downstream monitor, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (m_stb === 1'b1) begin
        if (stb_prev) stb_long++;
        iss_q.push_back('{cyc, grant, m_rw, m_addr, m_dtw});
      end
      stb_prev = (m_stb === 1'b1);
      if (i0_ack === 1'b1) begin
        ack0_hi++;
        if (!a0_prev) ack0_pulses++;
      end
      if (i1_ack === 1'b1) begin
        ack1_hi++;
        if (!a1_prev) ack1_pulses++;
      end
      a0_prev = (i0_ack === 1'b1);
      a1_prev = (i1_ack === 1'b1);
    end
  end

  // ext_sram model: acks tb_lat cycles after it sees m_stb, ignoring reset on purpose
  initial begin
    m_ack = 1'b0;
    m_dtr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_stb === 1'b1) begin
        repeat (tb_lat) begin
          @(posedge clk);
          #1;
        end
        m_ack = 1'b1;
        m_dtr = tb_rdata;
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_dtr = '0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t        vecs[5];
  logic [31:0] last_dtr[2];
  int          exp_g[10];
  logic        ok, ok2, got0, got1;
  logic [31:0] dtr;
  int          s0, s1, n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1002, 32'h0,         32'hDEAD_BEEF, 5, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         1, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hAAAA_5555, 2, 1'b0, 32'hAAAA_5555};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0F0F_0F0F, 3, 1'b1, 32'h0F0F_0F0F};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1, 1'b0, 32'h5A5A_5A5A};
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(3);
    chk("rst_ctrl", {26'h0, m_stb, m_rw, i0_ack, i1_ack, grant, busy}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_dtw", m_dtw, 32'h0);
    chk("rst_i0_dtr", i0_dtr, 32'h0);
    chk("rst_i1_dtr", i1_dtr, 32'h0);
    reset = 1'b0;
    tick(2);
    chk("idle_no_issue", iss_q.size(), 0);

    last_dtr[0] = '0;
    last_dtr[1] = '0;
    for (int v = 0; v < 5; v++) begin
      s0 = ack0_hi;
      s1 = ack1_hi;
      iss_q.delete();
      tb_lat = vecs[v].lat;
      tb_rdata = vecs[v].rdata;
      drive_port(vecs[v].port, 1'b1, vecs[v].rw, vecs[v].addr, vecs[v].dtw);
      wait_ack(vecs[v].port, 40, ok, dtr);
      drive_port(vecs[v].port, 1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("v%0d_ack_seen", v), ok, 1);
      chk($sformatf("v%0d_dtr", v), dtr, vecs[v].exp_dtr);
      tick(2);
      chk($sformatf("v%0d_issues", v), iss_q.size(), 1);
      if (iss_q.size() > 0) begin
        chk($sformatf("v%0d_grant", v), iss_q[0].g, vecs[v].exp_grant);
        chk($sformatf("v%0d_m_addr", v), iss_q[0].addr, vecs[v].addr);
        chk($sformatf("v%0d_m_rw", v), iss_q[0].rw, vecs[v].rw);
        chk($sformatf("v%0d_m_dtw", v), iss_q[0].dtw, vecs[v].dtw);
      end
      chk($sformatf("v%0d_ack0_cycles", v), ack0_hi - s0, vecs[v].port ? 0 : 1);
      chk($sformatf("v%0d_ack1_cycles", v), ack1_hi - s1, vecs[v].port ? 1 : 0);
      chk($sformatf("v%0d_other_dtr", v), vecs[v].port ? i0_dtr : i1_dtr,
          last_dtr[vecs[v].port ? 0 : 1]);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      last_dtr[vecs[v].port ? 1 : 0] = vecs[v].exp_dtr;
    end

    // Simultaneous requests: data port goes first, fetch on the following IDLE
    iss_q.delete();
    tb_lat = 1;
    tb_rdata = 32'h1111_2222;
    drive_port(1'b1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    drive_port(1'b0, 1'b1, 1'b0, 32'h30, 32'h0);
    got0 = 1'b0;
    got1 = 1'b0;
    n = 0;
    while (!(got0 && got1) && n < 60) begin
      tick(1);
      if (i1_ack) begin got1 = 1'b1; drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); end
      if (i0_ack) begin got0 = 1'b1; drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); end
      n++;
    end
    tick(2);
    chk("sim_both_acked", {got0, got1}, 2'b11);
    chk("sim_issues", iss_q.size(), 2);
    if (iss_q.size() >= 2) begin
      chk("sim_first_grant", iss_q[0].g, 1);
      chk("sim_first_rw", iss_q[0].rw, 1);
      chk("sim_first_dtw", iss_q[0].dtw, 32'h1234_5678);
      chk("sim_first_addr", iss_q[0].addr, 32'h20);
      chk("sim_second_grant", iss_q[1].g, 0);
      chk("sim_second_addr", iss_q[1].addr, 32'h30);
    end

    // Starvation guard with both masters holding stb
    iss_q.delete();
    tb_lat = 1;
    drive_port(1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    n = 0;
    while (iss_q.size() < 10 && n < 200) begin
      tick(1);
      n++;
    end
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(8);
    chk("starve_issues", iss_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < iss_q.size())
        chk($sformatf("starve_grant%0d", i), iss_q[i].g, exp_g[i]);

    // Back-to-back from port 1: new request presented the cycle after ack
    iss_q.delete();
    tb_lat = 1;
    drive_port(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    wait_ack(1'b1, 20, ok, dtr);
    drive_port(1'b1, 1'b1, 1'b0, 32'h504, 32'h0);
    wait_ack(1'b1, 20, ok2, dtr);
    drive_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(2);
    chk("b2b_acks", {ok, ok2}, 2'b11);
    chk("b2b_issues", iss_q.size(), 2);
    if (iss_q.size() >= 2) begin
      chk("b2b_spacing", iss_q[1].cyc - iss_q[0].cyc, 4);
      chk("b2b_second_addr", iss_q[1].addr, 32'h504);
    end

    // Reset while in WAIT, then a stray downstream ack
    iss_q.delete();
    tb_lat = 5;
    tb_rdata = 32'h7777_7777;
    drive_port(1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    n = 0;
    while (iss_q.size() == 0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("rw_issued", iss_q.size(), 1);
    chk("rw_in_wait_busy", busy, 1);
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(1);
    reset = 1'b0;
    chk("rw_ctrl_zero", {26'h0, m_stb, m_rw, i0_ack, i1_ack, grant, busy}, 32'h0);
    chk("rw_m_addr_zero", m_addr, 32'h0);
    chk("rw_i0_dtr_zero", i0_dtr, 32'h0);
    chk("rw_i1_dtr_zero", i1_dtr, 32'h0);
    s0 = ack0_hi;
    s1 = ack1_hi;
    tick(8);
    chk("rw_stray_ack0", ack0_hi - s0, 0);
    chk("rw_stray_ack1", ack1_hi - s1, 0);
    chk("rw_no_reissue", iss_q.size(), 1);
    chk("rw_idle_busy", busy, 0);
    chk("rw_i0_dtr_kept_zero", i0_dtr, 32'h0);

    chk("stb_single_cycle", stb_long, 0);
    chk("ack0_single_cycle", ack0_hi, ack0_pulses);
    chk("ack1_single_cycle", ack1_hi, ack1_pulses);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
